cmip_bus_arb: RTL and testbench

CMIP_BUS_ARB -- requirements
Module: cmip_bus_arb

---
 rtl/cmip_bus_arb.sv | 151 +++++++++++++++
 tb/tb_cmip_bus_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmip_bus_arb.sv
// Round-robin arbiter that lets REQ_NUM requesters share one fixed-latency pipeline, issuing at most one transfer per cycle.
// Latency: grant and issue are registered one cycle after the request. The response appears PIPE_DELAY cycles after the issue strobe.
// Backpressure: a requester holds its request and data until it sees its grant. A flush stops new issues until in-flight work drains.
module cmip_bus_arb #(
    parameter int REQ_NUM    = 4,
    parameter int DATA_WDTH  = 8,
    parameter int PIPE_DELAY = 2,
    localparam int ID_W      = $clog2(REQ_NUM),
    localparam int CNT_W     = $clog2(PIPE_DELAY + 1)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [REQ_NUM-1:0]             i_req,
    input  logic [REQ_NUM*DATA_WDTH-1:0]   i_din,
    input  logic                           i_flush,
    output logic [REQ_NUM-1:0]             o_gnt,
    output logic                           o_pipe_vld,
    output logic [DATA_WDTH-1:0]           o_pipe_din,
    output logic [ID_W-1:0]                o_pipe_id,
    input  logic [DATA_WDTH-1:0]           i_pipe_dout,
    output logic [REQ_NUM-1:0]             o_rsp_vld,
    output logic [DATA_WDTH-1:0]           o_rsp_data,
    output logic                           o_busy,
    output logic                           o_flush_done
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [REQ_NUM-1:0]     gnt_q, gnt_d;
    logic                   pipe_vld_q;
    logic [DATA_WDTH-1:0]   pipe_din_q, pipe_din_d;
    logic [ID_W-1:0]        pipe_id_q;
    logic [ID_W-1:0]        last_q;
    logic [PIPE_DELAY-1:0]  tag_vld_q;
    logic [ID_W-1:0]        tag_id_q [PIPE_DELAY];
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [REQ_NUM-1:0]     cand;
    logic [ID_W-1:0]        scan_idx;
    logic [ID_W-1:0]        win_idx;
    logic                   win_found;
    logic                   issue;
    logic [REQ_NUM-1:0]     rsp_vld;
    logic                   rsp_any;

    // Round-robin search: first candidate above the last winner, wrapping; last grantee is masked out
    always_comb begin
        cand      = i_req & ~gnt_q;
        scan_idx  = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 1; i <= REQ_NUM; i++) begin
            scan_idx = ID_W'((int'(last_q) + i) % REQ_NUM);
            if (!win_found && cand[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // A flush seen in RUN takes priority over any pending request
    assign issue = (state_q == ST_RUN) && !i_flush && win_found;

    // Grant one-hot and the selected requester's data slice
    always_comb begin
        gnt_d      = '0;
        pipe_din_d = i_din[int'(win_idx)*DATA_WDTH +: DATA_WDTH];
        if (issue) begin
            gnt_d[win_idx] = 1'b1;
        end
    end

    // Flush FSM: stop issuing, wait for the pipeline to empty, then hold DONE while flush stays high
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (i_flush)        state_d = ST_DRAIN;
            ST_DRAIN: if (cnt_q == '0)    state_d = ST_DONE;
            ST_DONE:  if (!i_flush)       state_d = ST_RUN;
            default:                      state_d = ST_RUN;
        endcase
    end

    // Response strobe decodes the id in the oldest tag stage
    always_comb begin
        rsp_vld = '0;
        if (tag_vld_q[PIPE_DELAY-1]) begin
            rsp_vld[tag_id_q[PIPE_DELAY-1]] = 1'b1;
        end
    end

    assign rsp_any = tag_vld_q[PIPE_DELAY-1];

    // In-flight count tracks issue strobes that have not yet produced a response
    always_comb begin
        cnt_d = cnt_q;
        case ({pipe_vld_q, rsp_any})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Registered arbitration results, tag pipeline, counter and FSM state
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_RUN;
            gnt_q      <= '0;
            pipe_vld_q <= 1'b0;
            pipe_din_q <= '0;
            pipe_id_q  <= '0;
            last_q     <= ID_W'(REQ_NUM - 1);
            tag_vld_q  <= '0;
            for (int i = 0; i < PIPE_DELAY; i++) begin
                tag_id_q[i] <= '0;
            end
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            pipe_vld_q <= issue;
            if (issue) begin
                pipe_din_q <= pipe_din_d;
                pipe_id_q  <= win_idx;
                last_q     <= win_idx;
            end
            tag_vld_q[0] <= pipe_vld_q;
            tag_id_q[0]  <= pipe_id_q;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
            cnt_q      <= cnt_d;
        end
    end

    assign o_gnt        = gnt_q;
    assign o_pipe_vld   = pipe_vld_q;
    assign o_pipe_din   = pipe_din_q;
    assign o_pipe_id    = pipe_id_q;
    assign o_rsp_vld    = rsp_vld;
    assign o_rsp_data   = i_pipe_dout;
    assign o_busy       = (cnt_q != '0);
    assign o_flush_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_cmip_bus_arb.sv
// Bench for cmip_bus_arb with 4 requesters, 8-bit data and a 2-deep pipeline.
// A reference model built from issue history tracks what each cycle should show.
// The bench also plays the shared pipeline, returning issued data PIPE_DELAY cycles later.
module tb_cmip_bus_arb;

    localparam int RN = 4;
    localparam int DW = 8;
    localparam int PD = 2;
    localparam int HN = 4096;

    logic            clk;
    logic            rst_n;
    logic [RN-1:0]   req;
    logic [RN*DW-1:0] din;
    logic            flush;
    logic [RN-1:0]   gnt;
    logic            pipe_vld;
    logic [DW-1:0]   pipe_din;
    logic [1:0]      pipe_id;
    logic [DW-1:0]   pipe_dout;
    logic [RN-1:0]   rsp_vld;
    logic [DW-1:0]   rsp_data;
    logic            busy;
    logic            flush_done;

    cmip_bus_arb #(.REQ_NUM(RN), .DATA_WDTH(DW), .PIPE_DELAY(PD)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req        (req),
        .i_din        (din),
        .i_flush      (flush),
        .o_gnt        (gnt),
        .o_pipe_vld   (pipe_vld),
        .o_pipe_din   (pipe_din),
        .o_pipe_id    (pipe_id),
        .i_pipe_dout  (pipe_dout),
        .o_rsp_vld    (rsp_vld),
        .o_rsp_data   (rsp_data),
        .o_busy       (busy),
        .o_flush_done (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // Model state: 0 = RUN, 1 = DRAIN, 2 = DONE
    int            m_state;
    logic [RN-1:0] m_gnt;
    logic          m_vld;
    logic [DW-1:0] m_din;
    logic [1:0]    m_id;
    int            m_last;
    int            cyc;
    int            floor_cyc;
    bit            iss     [HN];
    int            iss_id  [HN];
    logic [DW-1:0] iss_dat [HN];
    logic [DW-1:0] env_dat [HN];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Number of issues made since the last reset whose response is still outstanding at cycle m
    function automatic int inflight(input int m);
        int c;
        c = 0;
        for (int v = m - PD; v <= m - 1; v++) begin
            if (v > floor_cyc && v >= 0 && iss[v]) c++;
        end
        return c;
    endfunction

    task automatic tick();
        int n, win, c, ns, v;
        bit rv;
        n = cyc + 1;
        if (!rst_n) begin
            m_state   = 0;
            m_gnt     = '0;
            m_vld     = 1'b0;
            m_din     = '0;
            m_id      = '0;
            m_last    = RN - 1;
            floor_cyc = n;
            iss[n]    = 1'b0;
        end else begin
            win = -1;
            if (m_state == 0 && !flush) begin
                for (int k = 1; k <= RN; k++) begin
                    c = (m_last + k) % RN;
                    if (win < 0 && req[c] && !m_gnt[c]) win = c;
                end
            end
            case (m_state)
                0:       ns = flush ? 1 : 0;
                1:       ns = (inflight(cyc) == 0) ? 2 : 1;
                default: ns = flush ? 2 : 0;
            endcase
            m_state = ns;
            m_gnt   = '0;
            m_vld   = (win >= 0);
            if (win >= 0) begin
                m_gnt[win] = 1'b1;
                m_din      = din[win*DW +: DW];
                m_id       = 2'(win);
                m_last     = win;
            end
            iss[n]     = m_vld;
            iss_id[n]  = win;
            iss_dat[n] = m_din;
        end
        @(posedge clk);
        cyc = n;
        #1;
        env_dat[cyc] = pipe_din;
        pipe_dout = (cyc >= PD) ? env_dat[cyc-PD] : '0;
        #1;
        v  = cyc - PD;
        rv = (v > floor_cyc) && (v >= 0) && iss[v];
        chk("gnt",        32'(gnt),        32'(m_gnt));
        chk("pipe_vld",   32'(pipe_vld),   32'(m_vld));
        chk("pipe_din",   32'(pipe_din),   32'(m_din));
        chk("pipe_id",    32'(pipe_id),    32'(m_id));
        chk("rsp_vld",    32'(rsp_vld),    rv ? (32'd1 << iss_id[v]) : 32'd0);
        if (rv) chk("rsp_data", 32'(rsp_data), 32'(iss_dat[v]));
        chk("busy",       32'(busy),       32'(inflight(cyc) != 0));
        chk("flush_done", 32'(flush_done), 32'(m_state == 2));
    endtask

    initial begin
        int w;
        n_chk = 0; n_fail = 0; cyc = 0; floor_cyc = 0;
        m_state = 0; m_gnt = '0; m_vld = 1'b0; m_din = '0; m_id = '0; m_last = RN - 1;
        for (int i = 0; i < HN; i++) begin iss[i] = 1'b0; iss_id[i] = 0; iss_dat[i] = '0; env_dat[i] = '0; end
        rst_n = 1'b0; req = '0; din = '0; flush = 1'b0; pipe_dout = '0;

        // Reset state
        tick(); tick();
        chk("rst_gnt",  32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(flush_done), 32'h0);
        chk("rst_rsp",  32'(rsp_vld), 32'h0);

        // Single request from requester 0
        rst_n = 1'b1; req = 4'b0001; din[7:0] = 8'h5A;
        tick();
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_din", 32'(pipe_din), 32'h5A);
        req = '0;
        tick(); tick();
        chk("single_rsp_vld",  32'(rsp_vld), 32'h1);
        chk("single_rsp_data", 32'(rsp_data), 32'h5A);
        tick(); tick();

        // All four requesting continuously after reset
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req = 4'b1111; din = 32'h44332211;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_seq", 32'(gnt), 32'd1 << (i % 4));
            if (i >= 1) chk("rr_busy", 32'(busy), 32'h1);
        end

        // Flush with two in flight
        flush = 1'b1;
        tick();
        chk("flush_nogrant", 32'(gnt), 32'h0);
        w = 0;
        while (flush_done !== 1'b1 && w < 20) begin tick(); w++; end
        chk("drain_done", 32'(flush_done), 32'h1);
        chk("drain_idle", 32'(busy), 32'h0);
        flush = 1'b0;
        tick(); tick();
        chk("resume_vld", 32'(pipe_vld), 32'h1);
        req = '0; tick(); tick(); tick();

        // Flush and request together
        flush = 1'b1; req = 4'b1111;
        tick();
        chk("flush_req_gnt", 32'(gnt), 32'h0);
        tick(); tick(); tick();
        flush = 1'b0; req = '0; tick(); tick();

        // Requesters 1 and 3 alternate once last winner is 1
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req = 4'b0010; din = 32'hD3C3B3A3;
        tick();
        chk("alt_first", 32'(gnt), 32'h2);
        req = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("alt_seq", 32'(gnt), (i % 2 == 0) ? 32'h8 : 32'h2);
        end

        // Reset with two in flight
        req = 4'b1111;
        tick(); tick();
        rst_n = 1'b0; req = '0;
        tick();
        chk("rst_mid_gnt",  32'(gnt), 32'h0);
        chk("rst_mid_vld",  32'(pipe_vld), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_mid_rsp1", 32'(rsp_vld), 32'h0);
        tick();
        chk("rst_mid_rsp2", 32'(rsp_vld), 32'h0);
        req = 4'b1111;
        tick();
        chk("rst_first_gnt", 32'(gnt), 32'h1);

        // Randomized traffic honoring the hold-until-grant handshake
        for (int t = 0; t < 800; t++) begin
            for (int k = 0; k < RN; k++) begin
                if (!(req[k] && !m_gnt[k])) begin
                    req[k] = 1'($urandom_range(0, 1));
                    din[k*DW +: DW] = 8'($urandom);
                end
            end
            if (flush) flush = ($urandom_range(0, 5) != 0);
            else       flush = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
